// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: word width, reset fetch address and FSM encoding.
// PC_BASE_ADDR is the single source for the PC register reset value as well.
package fetch_ctrl_pkg;

    localparam int                    WORD_WIDTH   = 32;
    localparam logic [WORD_WIDTH-1:0] PC_BASE_ADDR = 32'h0000_3000;
    localparam logic [WORD_WIDTH-1:0] FETCH_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    function automatic logic [WORD_WIDTH-1:0] seq_pc(input logic [WORD_WIDTH-1:0] pc);
        return pc + FETCH_STRIDE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bus between the fetch sequencer and imem.
// At most one transaction is in flight; req/addr stay stable until gnt.
interface fetch_ctrl_if #(
    parameter int WORD_W = fetch_ctrl_pkg::WORD_WIDTH
);
    logic              req;
    logic [WORD_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_ctrl_redirect_latch.sv
// Holds one pending redirect target; an exception always wins over a branch.
// The bypass outputs expose the redirect that would be applied this very cycle.
module fetch_ctrl_redirect_latch
    import fetch_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid_i,
    input  logic [WORD_W-1:0] exc_vector_i,
    input  logic              br_taken_i,
    input  logic [WORD_W-1:0] br_target_i,
    input  logic              apply_i,
    output logic              byp_valid_o,
    output logic [WORD_W-1:0] byp_tgt_o
);

    logic              pend_v_q, pend_v_d;
    logic [WORD_W-1:0] pend_tgt_q, pend_tgt_d;

    always_comb begin
        byp_valid_o = pend_v_q || exc_valid_i || br_taken_i;
        if (exc_valid_i)
            byp_tgt_o = exc_vector_i;
        else if (pend_v_q)
            byp_tgt_o = pend_tgt_q;
        else
            byp_tgt_o = br_target_i;

        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;
        if (exc_valid_i) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = exc_vector_i;
        end else if (br_taken_i && !pend_v_q) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = br_target_i;
        end
        // A same-cycle capture is consumed by the apply through the bypass.
        if (apply_i)
            pend_v_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q   <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives npc/stallF, runs the imem handshake, buffers one
// instruction across load-use stalls and applies branch/exception redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                WORD_W  = WORD_WIDTH,
    parameter logic [WORD_W-1:0] PC_BASE = PC_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc_i,
    output logic [WORD_W-1:0] npc_o,
    output logic              stallF_o,
    input  logic              hazard_stall_i,
    input  logic              br_taken_i,
    input  logic [WORD_W-1:0] br_target_i,
    input  logic              exc_valid_i,
    input  logic [WORD_W-1:0] exc_vector_i,
    fetch_ctrl_if.master      imem,
    output logic [WORD_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              flushD_o
);

    fetch_state_e      state_q;
    logic              req_q;
    logic [WORD_W-1:0] instr_q;
    logic              ivalid_q;
    logic [WORD_W-1:0] skid_q;

    logic              byp_v;
    logic [WORD_W-1:0] byp_tgt;
    logic              rsp, may_apply, apply;
    logic              deliver_mem, deliver_buf, to_skid;

    fetch_ctrl_redirect_latch #(.WORD_W(WORD_W)) u_redirect (
        .clk          (clk),
        .rst          (rst),
        .exc_valid_i  (exc_valid_i),
        .exc_vector_i (exc_vector_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .apply_i      (apply),
        .byp_valid_o  (byp_v),
        .byp_tgt_o    (byp_tgt)
    );

    // No transaction is outstanding in IDLE, HOLD, or WAIT on its response cycle.
    always_comb begin
        rsp         = (state_q == S_WAIT) && imem.rvalid;
        may_apply   = (state_q == S_IDLE) || (state_q == S_HOLD) || rsp;
        apply       = !rst && may_apply && byp_v;
        deliver_mem = rsp && !byp_v && !hazard_stall_i;
        deliver_buf = (state_q == S_HOLD) && !byp_v && !hazard_stall_i;
        to_skid     = rsp && !byp_v && hazard_stall_i;

        npc_o    = pc_i;
        stallF_o = 1'b1;
        flushD_o = 1'b0;
        if (rst) begin
            npc_o = PC_BASE;
        end else if (apply) begin
            npc_o    = byp_tgt;
            stallF_o = 1'b0;
            flushD_o = 1'b1;
        end else if (deliver_mem || deliver_buf) begin
            npc_o    = seq_pc(pc_i);
            stallF_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            instr_q  <= '0;
            ivalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem.gnt) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (to_skid) begin
                        state_q <= S_HOLD;
                    end else if (rsp) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (apply || deliver_buf) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
            endcase

            // IF/ID holds its word while decode is stalled, except when flushed.
            if (apply) begin
                ivalid_q <= 1'b0;
            end else if (deliver_mem) begin
                instr_q  <= imem.rdata;
                ivalid_q <= 1'b1;
            end else if (deliver_buf) begin
                instr_q  <= skid_q;
                ivalid_q <= 1'b1;
            end else if (!hazard_stall_i) begin
                ivalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (to_skid)
            skid_q <= imem.rdata;
    end

    assign imem.req      = req_q;
    assign imem.addr     = pc_i;
    assign instr_o       = instr_q;
    assign instr_valid_o = ivalid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against an instruction-level model of the fetch stage.
module tb_fetch_ctrl;

    localparam logic [31:0] PC_BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = PC_BASE;
    logic [31:0] npc_o;
    logic        stallF_o;
    logic        hazard_stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [31:0] exc_vector_i = '0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        flushD_o;

    fetch_ctrl_if #(.WORD_W(32)) bus ();

    fetch_ctrl #(.WORD_W(32), .PC_BASE(PC_BASE)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .npc_o          (npc_o),
        .stallF_o       (stallF_o),
        .hazard_stall_i (hazard_stall_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .exc_valid_i    (exc_valid_i),
        .exc_vector_i   (exc_vector_i),
        .imem           (bus),
        .instr_o        (instr_o),
        .instr_valid_o  (instr_valid_o),
        .flushD_o       (flushD_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    logic        rst_v = 1'b1, hz_v = 1'b0, br_v = 1'b0, exc_v = 1'b0;
    logic [31:0] brt_v = '0, excv_v = '0, rdata_v = '0;
    logic        want_gnt = 1'b0, want_rv = 1'b0, force_rv = 1'b0;

    // environment: PC register and memory
    logic [31:0] pc_nx = PC_BASE;
    logic        mem_busy = 1'b0;

    // reference model of the fetch stage
    logic        m_first = 1'b0, m_req = 1'b0, m_wait = 1'b0, m_skid = 1'b0;
    logic        m_pv = 1'b0, m_iv = 1'b0;
    logic [31:0] m_pt = '0, m_skid_w = '0, m_instr = '0, m_fetch = PC_BASE;

    // last observed outputs
    logic [31:0] o_npc, o_instr, o_addr;
    logic        o_stall, o_flush, o_iv, o_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic        rsp, free, rv, apply, deliver, to_skid;
        logic [31:0] rt, word;
        @(negedge clk);
        pc_i           = pc_nx;
        rst            = rst_v;
        hazard_stall_i = hz_v;
        br_taken_i     = br_v;
        br_target_i    = brt_v;
        exc_valid_i    = exc_v;
        exc_vector_i   = excv_v;
        bus.gnt        = !rst_v && want_gnt && bus.req;
        bus.rvalid     = (!rst_v && want_rv && mem_busy) || force_rv;
        bus.rdata      = rdata_v;
        #1;
        o_npc = npc_o; o_stall = stallF_o; o_flush = flushD_o;
        o_iv = instr_valid_o; o_instr = instr_o; o_req = bus.req; o_addr = bus.addr;

        chk("instr_valid", {31'd0, o_iv}, {31'd0, m_iv});
        chk("instr", o_instr, m_instr);
        chk("req", {31'd0, o_req}, {31'd0, m_req});
        if (m_req) chk("addr", o_addr, m_fetch);

        rsp = 1'b0; apply = 1'b0; deliver = 1'b0; to_skid = 1'b0; word = '0;
        if (rst_v) begin
            chk("rst_npc", o_npc, PC_BASE);
            chk("rst_stall", {31'd0, o_stall}, 32'd1);
            chk("rst_flush", {31'd0, o_flush}, 32'd0);
        end else begin
            rsp  = m_wait && bus.rvalid;
            free = m_first || m_skid || rsp;
            rv   = 1'b1;
            rt   = '0;
            if (exc_v)      rt = excv_v;
            else if (m_pv)  rt = m_pt;
            else if (br_v)  rt = brt_v;
            else            rv = 1'b0;
            apply   = free && rv;
            deliver = !apply && !hz_v && (rsp || m_skid);
            to_skid = !apply && rsp && hz_v;
            word    = rsp ? rdata_v : m_skid_w;
            chk("flushD", {31'd0, o_flush}, {31'd0, apply});
            chk("stallF", {31'd0, o_stall}, {31'd0, !(apply || deliver)});
            if (apply)        chk("npc_redirect", o_npc, rt);
            else if (deliver) chk("npc_seq", o_npc, m_fetch + 32'd4);
        end

        pc_nx = rst_v ? PC_BASE : (!o_stall ? o_npc : pc_i);
        if (rst_v || bus.rvalid) mem_busy = 1'b0;
        else if (bus.gnt)        mem_busy = 1'b1;

        if (rst_v) begin
            m_first = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_skid = 1'b0;
            m_pv = 1'b0; m_pt = '0; m_iv = 1'b0; m_instr = '0; m_fetch = PC_BASE;
        end else if (apply) begin
            m_iv = 1'b0; m_pv = 1'b0; m_skid = 1'b0; m_wait = 1'b0;
            m_req = 1'b1; m_first = 1'b0; m_fetch = rt;
        end else begin
            if (exc_v) begin
                m_pv = 1'b1; m_pt = excv_v;
            end else if (br_v && !m_pv) begin
                m_pv = 1'b1; m_pt = brt_v;
            end
            if (m_req && bus.gnt) begin
                m_req = 1'b0; m_wait = 1'b1;
            end
            if (m_first) begin
                m_first = 1'b0; m_req = 1'b1;
            end
            if (deliver) begin
                m_iv = 1'b1; m_instr = word; m_skid = 1'b0; m_wait = 1'b0;
                m_req = 1'b1; m_fetch = m_fetch + 32'd4;
            end else begin
                if (to_skid) begin
                    m_skid = 1'b1; m_skid_w = word; m_wait = 1'b0;
                end
                if (!hz_v) m_iv = 1'b0;
            end
        end
        br_v = 1'b0; exc_v = 1'b0; force_rv = 1'b0;
    endtask

    initial begin
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;

        // reset, then first fetch: immediate grant, response one cycle later
        rst_v = 1'b1; cyc(); cyc(); rst_v = 1'b0;
        cyc();
        chk("idle_req", {31'd0, o_req}, 32'd0);
        chk("idle_stall", {31'd0, o_stall}, 32'd1);
        want_gnt = 1'b1; cyc(); want_gnt = 1'b0;
        chk("first_addr", o_addr, 32'h0000_3000);
        want_rv = 1'b1; rdata_v = 32'h2408_0001; cyc(); want_rv = 1'b0;
        chk("first_npc", o_npc, 32'h0000_3004);
        chk("first_stall", {31'd0, o_stall}, 32'd0);
        cyc();
        chk("first_instr", o_instr, 32'h2408_0001);
        chk("first_valid", {31'd0, o_iv}, 32'd1);

        // response under a 3-cycle load-use stall
        want_gnt = 1'b1; cyc(); want_gnt = 1'b0;
        hz_v = 1'b1; want_rv = 1'b1; rdata_v = 32'h8C09_0004;
        for (int i = 0; i < 3; i++) begin
            cyc();
            want_rv = 1'b0;
            chk("hold_stall", {31'd0, o_stall}, 32'd1);
            chk("hold_instr", o_instr, 32'h2408_0001);
        end
        hz_v = 1'b0; cyc();
        chk("release_npc", o_npc, 32'h0000_3008);
        chk("release_stall", {31'd0, o_stall}, 32'd0);
        cyc();
        chk("release_instr", o_instr, 32'h8C09_0004);
        chk("release_valid", {31'd0, o_iv}, 32'd1);

        // branch while waiting, response two cycles later is discarded
        want_gnt = 1'b1; cyc(); want_gnt = 1'b0;
        br_v = 1'b1; brt_v = 32'h0000_3100; cyc();
        chk("br_wait_flush", {31'd0, o_flush}, 32'd0);
        cyc();
        want_rv = 1'b1; rdata_v = 32'hDEAD_0001; cyc(); want_rv = 1'b0;
        chk("br_npc", o_npc, 32'h0000_3100);
        chk("br_flush", {31'd0, o_flush}, 32'd1);
        cyc();
        chk("br_flush_once", {31'd0, o_flush}, 32'd0);
        chk("br_addr", o_addr, 32'h0000_3100);
        chk("br_valid", {31'd0, o_iv}, 32'd0);

        // exception overrides a pending branch; later branch ignored
        want_gnt = 1'b1; cyc(); want_gnt = 1'b0;
        br_v = 1'b1; brt_v = 32'h0000_3100; cyc();
        exc_v = 1'b1; excv_v = 32'h0000_4180; cyc();
        br_v = 1'b1; brt_v = 32'h0000_5000; cyc();
        want_rv = 1'b1; rdata_v = 32'hDEAD_0002; cyc(); want_rv = 1'b0;
        chk("exc_npc", o_npc, 32'h0000_4180);
        chk("exc_flush", {31'd0, o_flush}, 32'd1);
        cyc();
        chk("exc_addr", o_addr, 32'h0000_4180);

        // branch and response in the same cycle
        want_gnt = 1'b1; cyc(); want_gnt = 1'b0;
        br_v = 1'b1; brt_v = 32'h0000_3300; want_rv = 1'b1; rdata_v = 32'hDEAD_0003;
        cyc(); want_rv = 1'b0;
        chk("same_npc", o_npc, 32'h0000_3300);
        cyc();
        chk("same_valid", {31'd0, o_iv}, 32'd0);

        // reset while waiting, then a stray response
        want_gnt = 1'b1; cyc(); want_gnt = 1'b0;
        rst_v = 1'b1; cyc(); rst_v = 1'b0;
        force_rv = 1'b1; rdata_v = 32'hBAD0_BAD0; cyc();
        chk("stray_valid", {31'd0, o_iv}, 32'd0);
        chk("stray_instr", o_instr, 32'd0);
        chk("stray_req", {31'd0, o_req}, 32'd0);
        cyc();
        chk("post_rst_req", {31'd0, o_req}, 32'd1);
        chk("post_rst_addr", o_addr, 32'h0000_3000);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_v    = ($urandom_range(299) == 0);
            hz_v     = ($urandom_range(3) == 0);
            br_v     = ($urandom_range(7) == 0);
            brt_v    = $urandom & 32'hFFFF_FFFC;
            exc_v    = ($urandom_range(15) == 0);
            excv_v   = $urandom & 32'hFFFF_FFFC;
            want_gnt = $urandom_range(1) == 1;
            want_rv  = ($urandom_range(2) == 0);
            rdata_v  = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
